// File: rtl/scnn_sparse_encoder_if.sv
// Dense-in / sparse-out handshake bundle for scnn_sparse_encoder.
// master drives the dense stream and accepts groups; slave is the encoder.
interface scnn_sparse_encoder_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned IDX_W  = 4,
   parameter int unsigned VEC    = 4
) ();

   logic                       in_valid;
   logic                       in_ready;
   logic [DATA_W-1:0]          in_data;
   logic                       in_last;
   logic                       out_valid;
   logic                       out_ready;
   logic [VEC*DATA_W-1:0]      out_val;
   logic [VEC*IDX_W-1:0]       out_idx;
   logic [$clog2(VEC+1)-1:0]   out_count;
   logic                       out_last;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_val, out_idx, out_count, out_last
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_val, out_idx, out_count, out_last
   );

endinterface

// File: rtl/scnn_sparse_encoder.sv
// Packs a dense element stream into groups of VEC non-zero values with zero-run indices.
// Staging collects one group while the output register presents the previous one.
module scnn_sparse_encoder #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned IDX_W  = 4,
   parameter int unsigned VEC    = 4
) (
   input logic                  clk,
   input logic                  rst_n,
   scnn_sparse_encoder_if.slave bus_io
);

   localparam int unsigned CntW = $clog2(VEC + 1);
   localparam logic [IDX_W-1:0] MaxRun = '1;

   typedef enum logic [0:0] {StAccum, StHold} state_e;

   state_e                         state_q;
   logic                           in_ready_q;
   logic [IDX_W-1:0]               run_q;
   logic [VEC-1:0][DATA_W-1:0]     stg_val_q;
   logic [VEC-1:0][IDX_W-1:0]      stg_idx_q;
   logic [CntW-1:0]                stg_cnt_q;
   logic                           stg_last_q;
   logic                           out_valid_q;
   logic [VEC*DATA_W-1:0]          out_val_q;
   logic [VEC*IDX_W-1:0]           out_idx_q;
   logic [CntW-1:0]                out_cnt_q;
   logic                           out_last_q;

   logic                           accept;
   logic                           is_zero;
   logic                           append;
   logic                           close;
   logic                           out_free;
   logic [VEC-1:0][DATA_W-1:0]     grp_val;
   logic [VEC-1:0][IDX_W-1:0]      grp_idx;
   logic [CntW-1:0]                grp_cnt;

   always_comb begin
      accept   = bus_io.in_valid && in_ready_q;
      is_zero  = (bus_io.in_data == '0);
      // A zero on the closing element would only encode trailing zeros, so it never appends.
      append   = !is_zero || (run_q == MaxRun && !bus_io.in_last);
      out_free = !out_valid_q || bus_io.out_ready;
      grp_val  = stg_val_q;
      grp_idx  = stg_idx_q;
      grp_cnt  = stg_cnt_q;
      for (int unsigned i = 0; i < VEC; i++) begin
         if (accept && append && stg_cnt_q == CntW'(i)) begin
            grp_val[i] = bus_io.in_data;
            grp_idx[i] = is_zero ? MaxRun : run_q;
         end
      end
      if (accept && append) begin
         grp_cnt = stg_cnt_q + CntW'(1);
      end
      close = accept && (grp_cnt == CntW'(VEC) || bus_io.in_last);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StAccum;
         in_ready_q  <= 1'b1;
         run_q       <= '0;
         stg_val_q   <= '0;
         stg_idx_q   <= '0;
         stg_cnt_q   <= '0;
         stg_last_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_val_q   <= '0;
         out_idx_q   <= '0;
         out_cnt_q   <= '0;
         out_last_q  <= 1'b0;
      end else begin
         if (out_valid_q && bus_io.out_ready) begin
            out_valid_q <= 1'b0;
         end
         unique case (state_q)
            StAccum: begin
               if (accept) begin
                  run_q <= (bus_io.in_last || append) ? '0 : run_q + IDX_W'(1);
                  if (close && out_free) begin
                     out_valid_q <= 1'b1;
                     out_val_q   <= grp_val;
                     out_idx_q   <= grp_idx;
                     out_cnt_q   <= grp_cnt;
                     out_last_q  <= bus_io.in_last;
                     stg_val_q   <= '0;
                     stg_idx_q   <= '0;
                     stg_cnt_q   <= '0;
                  end else begin
                     stg_val_q <= grp_val;
                     stg_idx_q <= grp_idx;
                     stg_cnt_q <= grp_cnt;
                     if (close) begin
                        stg_last_q <= bus_io.in_last;
                        state_q    <= StHold;
                        in_ready_q <= 1'b0;
                     end
                  end
               end
            end
            StHold: begin
               // out_valid is necessarily high here; out_ready retires it and frees the slot.
               if (bus_io.out_ready) begin
                  out_valid_q <= 1'b1;
                  out_val_q   <= stg_val_q;
                  out_idx_q   <= stg_idx_q;
                  out_cnt_q   <= stg_cnt_q;
                  out_last_q  <= stg_last_q;
                  stg_val_q   <= '0;
                  stg_idx_q   <= '0;
                  stg_cnt_q   <= '0;
                  stg_last_q  <= 1'b0;
                  state_q     <= StAccum;
                  in_ready_q  <= 1'b1;
               end
            end
         endcase
      end
   end

   assign bus_io.in_ready  = in_ready_q;
   assign bus_io.out_valid = out_valid_q;
   assign bus_io.out_val   = out_val_q;
   assign bus_io.out_idx   = out_idx_q;
   assign bus_io.out_count = out_cnt_q;
   assign bus_io.out_last  = out_last_q;

endmodule
